// File: rtl/csa_accum_ctrl_pkg.sv
// Shared definitions for the carry-save accumulator controller.
package csa_accum_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 4;

    // Controller states: collect operands, fold carries, hold result.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } csa_state_e;

endpackage : csa_accum_ctrl_pkg

// File: rtl/csa_vec.sv
// One row of full adders in carry-save form: W independent 3:2 compressors.
module csa_vec #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] s_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] maj_o
);

    // Per-bit sum and majority; the caller applies the carry shift.
    assign sum_o = s_i ^ c_i ^ x_i;
    assign maj_o = (s_i & c_i) | (s_i & x_i) | (c_i & x_i);

endmodule : csa_vec

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: keeps a redundant (S,C) total on one shared CSA row,
// then folds the carry vector back through the same row to produce the binary sum.
module csa_accum_ctrl
    import csa_accum_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+CNT_W-1:0]   out_sum,
    output logic [CNT_W:0]           out_count,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int unsigned ACC_W = WIDTH + CNT_W;
    localparam int unsigned CNT_N = CNT_W + 1;

    csa_state_e       state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic [CNT_N-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [ACC_W-1:0] row_x_c;
    logic [ACC_W-1:0] row_sum_c;
    logic [ACC_W-1:0] row_maj_c;
    logic [ACC_W-1:0] row_carry_c;
    logic [CNT_N-1:0] cnt_inc_c;
    logic             accept_c;
    logic             pop_c;

    // Single shared compressor row; operand input is zero while resolving.
    csa_vec #(.W(ACC_W)) u_row (
        .s_i   (s_q),
        .c_i   (c_q),
        .x_i   (row_x_c),
        .sum_o (row_sum_c),
        .maj_o (row_maj_c)
    );

    // Row operand select, carry shift and handshake qualifiers.
    always_comb begin
        row_x_c     = (state_q == ST_RESOLVE) ? '0 : ACC_W'(in_data);
        row_carry_c = {row_maj_c[ACC_W-2:0], 1'b0};
        cnt_inc_c   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_N'(1);
        accept_c    = in_valid & in_ready_q;
        pop_c       = out_valid_q & out_ready;
    end

    // Next-state and datapath update; registers hold unless a step occurs.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    s_d     = row_sum_c;
                    c_d     = row_carry_c;
                    ovf_d   = ovf_q | row_maj_c[ACC_W-1];
                    cnt_d   = CNT_N'(1);
                    state_d = in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept_c) begin
                    s_d     = row_sum_c;
                    c_d     = row_carry_c;
                    ovf_d   = ovf_q | row_maj_c[ACC_W-1];
                    cnt_d   = cnt_inc_c;
                    state_d = in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                if (c_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    s_d   = row_sum_c;
                    c_d   = row_carry_c;
                    ovf_d = ovf_q | row_maj_c[ACC_W-1];
                end
            end
            ST_DONE: begin
                if (pop_c) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and state-decoded handshake flags, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_ACCUM);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = s_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule : csa_accum_ctrl
